// File: rtl/ps2_host_transmitter_if.sv
// Command/status and open-drain line signals between a PS/2 host transmitter and its client.
// "master" is the client side (issues bytes, models the physical lines); "slave" is the transmitter.
interface ps2_host_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       rx_inhibit;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_done, tx_err, err_code
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_drive_low, ps2_data_drive_low, rx_inhibit, tx_done, tx_err, err_code
  );
endinterface

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift byte+parity+stop on the
// device clock, then check the device ACK. One byte in flight; TX_VALID ignored while busy.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_host_transmitter_if.slave   bus
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fe;
  logic [7:0]             shreg;
  logic                   parity;
  logic [3:0]             edge_cnt;
  logic [IW-1:0]          inh_cnt;
  logic [TW-1:0]          to_cnt;
  logic                   ack_ok;
  logic                   tx_ready_q, clk_low_q, data_low_q, rx_inhibit_q, tx_done_q, tx_err_q;
  logic [1:0]             err_code_q;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;

  // Synchronizers reset to the idle-high bus level so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_ready_q   <= 1'b1;
      clk_low_q    <= 1'b0;
      data_low_q   <= 1'b0;
      rx_inhibit_q <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_err_q     <= 1'b0;
      err_code_q   <= 2'b00;
      shreg        <= '0;
      parity       <= 1'b0;
      edge_cnt     <= '0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      ack_ok       <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          clk_low_q    <= 1'b0;
          data_low_q   <= 1'b0;
          rx_inhibit_q <= 1'b0;
          // tx_ready stays low through the DONE/ERR pulse cycle and rises one cycle later.
          if (bus.tx_valid && tx_ready_q) begin
            shreg        <= bus.tx_data;
            parity       <= ~^bus.tx_data;
            err_code_q   <= 2'b00;
            inh_cnt      <= '0;
            tx_ready_q   <= 1'b0;
            rx_inhibit_q <= 1'b1;
            clk_low_q    <= 1'b1;
            state        <= INHIBIT;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            data_low_q <= 1'b1;
            state      <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        REQ: begin
          clk_low_q <= 1'b0;
          edge_cnt  <= '0;
          to_cnt    <= '0;
          state     <= SHIFT;
        end
        SHIFT, WAIT_IDLE: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            clk_low_q    <= 1'b0;
            data_low_q   <= 1'b0;
            rx_inhibit_q <= 1'b0;
            tx_err_q     <= 1'b1;
            err_code_q   <= 2'b01;
            state        <= IDLE;
          end else if (state == SHIFT) begin
            if (fe) begin
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt < 4'd8) begin
                data_low_q <= ~shreg[0];
                shreg      <= {1'b0, shreg[7:1]};
              end else if (edge_cnt == 4'd8) begin
                data_low_q <= ~parity;
              end else if (edge_cnt == 4'd9) begin
                data_low_q <= 1'b0;
              end else begin
                ack_ok <= ~data_s;
                state  <= WAIT_IDLE;
              end
            end
          end else if (clk_s && data_s) begin
            rx_inhibit_q <= 1'b0;
            tx_done_q    <= ack_ok;
            tx_err_q     <= ~ack_ok;
            if (!ack_ok) err_code_q <= 2'b10;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready           = tx_ready_q;
  assign bus.ps2_clk_drive_low  = clk_low_q;
  assign bus.ps2_data_drive_low = data_low_q;
  assign bus.rx_inhibit         = rx_inhibit_q;
  assign bus.tx_done            = tx_done_q;
  assign bus.tx_err             = tx_err_q;
  assign bus.err_code           = err_code_q;

endmodule
